// File: rtl/uart_pkg.sv
// Shared definitions for the uart_tx arbiter: FSM encoding, width helper and
// the default frame timeout.
package uart_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_GRANT = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        GRANT = ST_GRANT,
        START = ST_START,
        WAIT  = ST_WAIT,
        DONE  = ST_DONE
    } arb_state_t;

    localparam int DEFAULT_TIMEOUT_CYCLES = 2_000_000;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Rotating priority encoder: first valid requester at or after ptr, wrapping
// modulo N_REQ.
module rr_pick
    import uart_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDW   = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [IDW-1:0]   ptr,
    output logic             any_valid,
    output logic [IDW-1:0]   sel_id
);

    always_comb begin
        logic           found;
        logic [IDW-1:0] idx;
        any_valid = |req_valid;
        sel_id    = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = IDW'((int'(ptr) + k) % N_REQ);
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                sel_id = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among N_REQ byte producers.
// Optional frame timeout enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [8*N_REQ-1:0]        req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic [N_REQ-1:0]          req_done,
    output logic [N_REQ-1:0]          req_err,
    output logic                      start_tx,
    output logic [7:0]                tx_data,
    input  logic                      tx_done,
    output logic                      busy,
    output logic [clog2(N_REQ)-1:0]   grant_id
);

    localparam int IDW = clog2(N_REQ);

    arb_state_t      state;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  sel_id;
    logic            any_valid;
    logic            tx_done_q;
    logic            tx_done_rise;
    logic [N_REQ-1:0] sel_oh;
    logic [N_REQ-1:0] gnt_oh;
    logic [IDW-1:0]  ptr_next;
    logic [7:0]      req_byte [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_byte
        assign req_byte[i] = req_data[8*i +: 8];
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_pick (
        .req_valid (req_valid),
        .ptr       (ptr),
        .any_valid (any_valid),
        .sel_id    (sel_id)
    );

    assign sel_oh       = N_REQ'(1) << sel_id;
    assign gnt_oh       = N_REQ'(1) << grant_id;
    assign ptr_next     = (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
    assign tx_done_rise = tx_done & ~tx_done_q;

    // A level already high when WAIT is entered is not a completion edge.
    always_ff @(posedge clk) begin
        tx_done_q <= tx_done;
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] to_cnt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            grant_id  <= '0;
            tx_data   <= 8'h00;
            req_ready <= '0;
            req_done  <= '0;
            start_tx  <= 1'b0;
            busy      <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            req_err   <= '0;
            to_cnt    <= '0;
`endif
        end else begin
            req_ready <= '0;
            req_done  <= '0;
            start_tx  <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            req_err   <= '0;
`endif
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        grant_id  <= sel_id;
                        req_ready <= sel_oh;
                        busy      <= 1'b1;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    tx_data  <= req_byte[grant_id];
                    start_tx <= 1'b1;
                    state    <= START;
                end
                START: begin
`ifdef UART_ARB_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                    state  <= WAIT;
                end
                WAIT: begin
                    if (tx_done_rise) begin
                        req_done <= gnt_oh;
                        state    <= DONE;
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    else if (to_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        req_err <= gnt_oh;
                        state   <= DONE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                DONE: begin
                    ptr   <= ptr_next;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef UART_ARB_TIMEOUT_EN
    assign req_err = '0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus a randomized
// run against a queue-free round-robin reference model.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 50;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_ready, req_done, req_err;
    logic           start_tx;
    logic [7:0]     tx_data;
    logic           tx_done;
    logic           busy;
    logic [1:0]     grant_id;

    int n_checks = 0;
    int n_fail   = 0;
    int m_ptr    = 0;

    // observations of the most recent frame
    int         f_lat_ready, f_lat_start, f_lat_done, f_gnt;
    logic [N-1:0] f_rdy, f_done, f_err;
    logic [7:0] f_txd;
    bit         f_txd_stable, f_tail;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .req_done(req_done), .req_err(req_err),
        .start_tx(start_tx), .tx_data(tx_data), .tx_done(tx_done),
        .busy(busy), .grant_id(grant_id)
    );

    function automatic int model_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic logic [7:0] byte_of(input int i);
        return req_data[8*i +: 8];
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_byte(input int i, input logic [7:0] b);
        req_data[8*i +: 8] = b;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; tx_done = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        m_ptr = 0;
    endtask

    // Drives one frame through the arbiter and records what it observed.
    // dly < 0 means uart_tx never reports completion.
    task automatic run_frame(input bit drop, input int dly);
        int n;
        int gid;
        f_lat_ready = -1; f_lat_start = -1; f_lat_done = -1; f_gnt = -1;
        f_rdy = '0; f_done = '0; f_err = '0; f_txd = 8'h00; f_txd_stable = 1'b0; f_tail = 1'b0;
        gid = -1;
        n = 0;
        do begin tick(); n++; end while (req_ready == '0 && n < 8);
        if (req_ready != '0) f_lat_ready = n;
        f_rdy = req_ready;
        f_gnt = int'(grant_id);
        for (int i = 0; i < N; i++) if (req_ready[i]) gid = i;
        if (drop && gid >= 0) req_valid[gid] = 1'b0;
        n = 0;
        do begin tick(); n++; end while (!start_tx && n < 8);
        if (start_tx) f_lat_start = n;
        f_txd = tx_data;
        if (dly >= 0) begin
            repeat (dly) tick();
            tx_done = 1'b1;
            n = 0;
            do begin tick(); n++; tx_done = 1'b0; end
            while ((req_done | req_err) == '0 && n < 16);
        end else begin
            n = 0;
            do begin tick(); n++; end
            while ((req_done | req_err) == '0 && n < TO + 20);
        end
        if ((req_done | req_err) != '0) f_lat_done = n;
        f_done = req_done;
        f_err  = req_err;
        f_txd_stable = (tx_data === f_txd);
        tick();
        f_tail = (req_done == '0 && req_err == '0 && busy == 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '1; req_data = 32'hDEADBEEF; tx_done = 1'b0;
        repeat (3) tick();
        n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL reset_req_ready: got %0h expected 0", req_ready); end
        n_checks++; if (req_done !== '0) begin n_fail++; $display("FAIL reset_req_done: got %0h expected 0", req_done); end
        n_checks++; if (req_err !== '0) begin n_fail++; $display("FAIL reset_req_err: got %0h expected 0", req_err); end
        n_checks++; if (start_tx !== 1'b0) begin n_fail++; $display("FAIL reset_start_tx: got %0b expected 0", start_tx); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
        n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %0h expected 0", tx_data); end
        req_valid = '0;
        rst = 1'b0;
        m_ptr = 0;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        req_data = $urandom;
        set_byte(2, 8'hA5);
        req_valid = 4'b0100;
        run_frame(1'b1, 5);
        n_checks++; if (f_lat_ready !== 1) begin n_fail++; $display("FAIL single_ready_latency: got %0d expected 1", f_lat_ready); end
        n_checks++; if (f_rdy !== 4'b0100) begin n_fail++; $display("FAIL single_req_ready: got %0h expected 4", f_rdy); end
        n_checks++; if (f_gnt !== 2) begin n_fail++; $display("FAIL single_grant_id: got %0d expected 2", f_gnt); end
        n_checks++; if (f_lat_start !== 1) begin n_fail++; $display("FAIL single_start_latency: got %0d expected 1", f_lat_start); end
        n_checks++; if (f_txd !== 8'hA5) begin n_fail++; $display("FAIL single_tx_data: got %0h expected a5", f_txd); end
        n_checks++; if (f_lat_done !== 1) begin n_fail++; $display("FAIL single_done_latency: got %0d expected 1", f_lat_done); end
        n_checks++; if (f_done !== 4'b0100) begin n_fail++; $display("FAIL single_req_done: got %0h expected 4", f_done); end
        n_checks++; if (f_err !== '0) begin n_fail++; $display("FAIL single_req_err: got %0h expected 0", f_err); end
        n_checks++; if (!f_txd_stable) begin n_fail++; $display("FAIL single_tx_data_stable: got 0 expected 1"); end
        n_checks++; if (!f_tail) begin n_fail++; $display("FAIL single_pulse_end: got 0 expected 1"); end
        m_ptr = 3;
    endtask

    task automatic test_round_robin();
        int prev;
        logic [7:0] expb;
        do_reset();
        req_data = {$urandom};
        req_valid = 4'b1111;
        prev = -1;
        for (int f = 0; f < 5; f++) begin
            expb = byte_of(f % N);
            run_frame(1'b0, 20);
            n_checks++; if (f_gnt !== f % N) begin n_fail++; $display("FAIL rr_order[%0d]: got %0d expected %0d", f, f_gnt, f % N); end
            n_checks++; if (f_gnt === prev) begin n_fail++; $display("FAIL rr_repeat[%0d]: got %0d expected not %0d", f, f_gnt, prev); end
            n_checks++; if (f_txd !== expb) begin n_fail++; $display("FAIL rr_tx_data[%0d]: got %0h expected %0h", f, f_txd, expb); end
            n_checks++; if (f_done !== (N'(1) << (f % N))) begin n_fail++; $display("FAIL rr_done[%0d]: got %0h expected %0h", f, f_done, N'(1) << (f % N)); end
            prev = f_gnt;
            set_byte(f % N, 8'($urandom));
        end
        req_valid = '0;
        m_ptr = 1;
        tick(); tick();
    endtask

    task automatic test_wrap();
        logic [7:0] b1, b3;
        do_reset();
        req_valid = 4'b0100;
        run_frame(1'b1, 3);
        b1 = 8'($urandom); b3 = 8'($urandom);
        set_byte(1, b1); set_byte(3, b3);
        req_valid = 4'b1010;
        run_frame(1'b1, 3);
        n_checks++; if (f_gnt !== 3) begin n_fail++; $display("FAIL wrap_first: got %0d expected 3", f_gnt); end
        n_checks++; if (f_txd !== b3) begin n_fail++; $display("FAIL wrap_first_data: got %0h expected %0h", f_txd, b3); end
        run_frame(1'b1, 3);
        n_checks++; if (f_gnt !== 1) begin n_fail++; $display("FAIL wrap_second: got %0d expected 1", f_gnt); end
        n_checks++; if (f_txd !== b1) begin n_fail++; $display("FAIL wrap_second_data: got %0h expected %0h", f_txd, b1); end
        m_ptr = 2;
    endtask

    task automatic test_stale_done();
        int n, early, total, lat, busy_low;
        tx_done = 1'b1;
        req_valid = 4'b0001;
        n = 0;
        do begin tick(); n++; end while (req_ready == '0 && n < 8);
        req_valid = '0;
        n = 0;
        do begin tick(); n++; end while (!start_tx && n < 8);
        early = 0; busy_low = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (req_done != '0) early++;
            if (!busy) busy_low++;
        end
        tx_done = 1'b0;
        tick(); tick();
        tx_done = 1'b1;
        total = 0; lat = -1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (req_done != '0) begin total++; if (lat < 0) lat = i; end
        end
        tx_done = 1'b0;
        n_checks++; if (early !== 0) begin n_fail++; $display("FAIL stale_early_done: got %0d expected 0", early); end
        n_checks++; if (busy_low !== 0) begin n_fail++; $display("FAIL stale_left_wait: got %0d expected 0", busy_low); end
        n_checks++; if (total !== 1) begin n_fail++; $display("FAIL stale_done_count: got %0d expected 1", total); end
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL stale_done_latency: got %0d expected 1", lat); end
        m_ptr = 1;
    endtask

    task automatic test_mid_reset();
        int n, pulses, busy_hi;
        do_reset();
        req_valid = 4'b0010;
        run_frame(1'b1, 2);
        n_checks++; if (f_gnt !== 1) begin n_fail++; $display("FAIL midrst_setup: got %0d expected 1", f_gnt); end
        req_valid = 4'b1000;
        n = 0;
        do begin tick(); n++; end while (req_ready == '0 && n < 8);
        req_valid = '0;
        n = 0;
        do begin tick(); n++; end while (!start_tx && n < 8);
        repeat (3) tick();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_in_wait: got %0b expected 1", busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %0b expected 0", busy); end
        n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL midrst_grant_id: got %0d expected 0", grant_id); end
        tx_done = 1'b1;
        pulses = 0; busy_hi = 0;
        for (int i = 0; i < 6; i++) begin
            if ((req_done | req_err) != '0) pulses++;
            if (busy) busy_hi++;
            tick();
            tx_done = 1'b0;
        end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL midrst_pulses: got %0d expected 0", pulses); end
        n_checks++; if (busy_hi !== 0) begin n_fail++; $display("FAIL midrst_idle: got %0d expected 0", busy_hi); end
        m_ptr = 0;
        req_valid = 4'b0101;
        run_frame(1'b1, 2);
        n_checks++; if (f_gnt !== 0) begin n_fail++; $display("FAIL midrst_ptr_cleared: got %0d expected 0", f_gnt); end
        run_frame(1'b1, 2);
        n_checks++; if (f_gnt !== 2) begin n_fail++; $display("FAIL midrst_next: got %0d expected 2", f_gnt); end
        m_ptr = 3;
    endtask

    task automatic test_random();
        logic [N-1:0] nv;
        logic [N-1:0] eoh;
        logic [7:0]   expb;
        int           exp_id;
        for (int f = 0; f < 30; f++) begin
            nv = N'($urandom_range(0, 15));
            for (int i = 0; i < N; i++)
                if (nv[i] && !req_valid[i]) begin
                    set_byte(i, 8'($urandom));
                    req_valid[i] = 1'b1;
                end
            if (req_valid == '0) begin
                exp_id = $urandom_range(0, N - 1);
                set_byte(exp_id, 8'($urandom));
                req_valid[exp_id] = 1'b1;
            end
            exp_id = model_pick(req_valid, m_ptr);
            expb   = byte_of(exp_id);
            eoh    = N'(1) << exp_id;
            run_frame(1'b1, $urandom_range(1, 8));
            n_checks++; if (f_gnt !== exp_id) begin n_fail++; $display("FAIL rand_grant[%0d]: got %0d expected %0d", f, f_gnt, exp_id); end
            n_checks++; if (f_rdy !== eoh) begin n_fail++; $display("FAIL rand_ready[%0d]: got %0h expected %0h", f, f_rdy, eoh); end
            n_checks++; if (f_txd !== expb) begin n_fail++; $display("FAIL rand_tx_data[%0d]: got %0h expected %0h", f, f_txd, expb); end
            n_checks++; if (f_done !== eoh) begin n_fail++; $display("FAIL rand_done[%0d]: got %0h expected %0h", f, f_done, eoh); end
            n_checks++; if (f_lat_start !== 1 || f_lat_done !== 1) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d/%0d expected 1/1", f, f_lat_start, f_lat_done); end
            m_ptr = (exp_id + 1) % N;
        end
        req_valid = '0;
        tick(); tick();
    endtask

`ifdef UART_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int exp_id;
        logic [N-1:0] eoh;
        req_data = {$urandom};
        req_valid = 4'b0110;
        exp_id = model_pick(req_valid, m_ptr);
        eoh = N'(1) << exp_id;
        run_frame(1'b1, -1);
        n_checks++; if (f_err !== eoh) begin n_fail++; $display("FAIL timeout_err: got %0h expected %0h", f_err, eoh); end
        n_checks++; if (f_done !== '0) begin n_fail++; $display("FAIL timeout_done: got %0h expected 0", f_done); end
        n_checks++; if (f_lat_done !== TO + 1) begin n_fail++; $display("FAIL timeout_latency: got %0d expected %0d", f_lat_done, TO + 1); end
        n_checks++; if (!f_tail) begin n_fail++; $display("FAIL timeout_pulse_end: got 0 expected 1"); end
        m_ptr = (exp_id + 1) % N;
        exp_id = model_pick(req_valid, m_ptr);
        run_frame(1'b1, 3);
        n_checks++; if (f_gnt !== exp_id) begin n_fail++; $display("FAIL timeout_next_grant: got %0d expected %0d", f_gnt, exp_id); end
        n_checks++; if (f_done !== (N'(1) << exp_id)) begin n_fail++; $display("FAIL timeout_next_done: got %0h expected %0h", f_done, N'(1) << exp_id); end
        m_ptr = (exp_id + 1) % N;
    endtask
`endif

    initial begin
        rst = 1'b1; req_valid = '0; req_data = '0; tx_done = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_stale_done();
        test_mid_reset();
        test_random();
`ifdef UART_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
